// File: rtl/latch_out_debounce.sv
// Synchronizes the raw latch output into the clk domain and debounces it:
// clean level, registered rise/fall strobes, pending-change flag, transition count.
module latch_out_debounce #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned STABLE_CNT  = 4,
    parameter int unsigned EVT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             q_in,
    output logic             level,
    output logic             rise,
    output logic             fall,
    output logic             busy,
    output logic [EVT_W-1:0] evt_cnt
);

    localparam int unsigned     CW       = $clog2(STABLE_CNT + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(STABLE_CNT - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   syncd;

    logic             level_q, level_d;
    logic             rise_q,  rise_d;
    logic             fall_q,  fall_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic [EVT_W-1:0] evt_q,   evt_d;

    // Pure flop chain: nothing may sit between synchronizer stages.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], q_in};
        end
    end

    assign syncd = sync_q[SYNC_STAGES-1];

    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        evt_d   = evt_q;
        if (syncd == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            level_d = syncd;
            cnt_d   = '0;
            rise_d  = syncd;
            fall_d  = ~syncd;
            evt_d   = evt_q + EVT_W'(1);
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            cnt_q   <= '0;
            evt_q   <= '0;
        end else begin
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            cnt_q   <= cnt_d;
            evt_q   <= evt_d;
        end
    end

    assign level   = level_q;
    assign rise    = rise_q;
    assign fall    = fall_q;
    assign busy    = (cnt_q != '0);
    assign evt_cnt = evt_q;

endmodule

// File: tb/tb_latch_out_debounce.sv
// Bench for latch_out_debounce: default instance plus a SYNC_STAGES=3/STABLE_CNT=1
// instance, both compared every cycle against a sample-history model.
module tb_latch_out_debounce;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       q_in = 1'b0;
    logic       level0, rise0, fall0, busy0;
    logic [7:0] evt0;
    logic       level1, rise1, fall1, busy1;
    logic [7:0] evt1;

    int checks = 0;
    int errors = 0;
    int rise_seen = 0;
    int fall_seen = 0;

    always #5 clk = ~clk;

    latch_out_debounce #(.SYNC_STAGES(2), .STABLE_CNT(4), .EVT_W(8)) u_dut0 (
        .clk(clk), .rst(rst), .q_in(q_in),
        .level(level0), .rise(rise0), .fall(fall0), .busy(busy0), .evt_cnt(evt0)
    );

    latch_out_debounce #(.SYNC_STAGES(3), .STABLE_CNT(1), .EVT_W(8)) u_dut1 (
        .clk(clk), .rst(rst), .q_in(q_in),
        .level(level1), .rise(rise1), .fall(fall1), .busy(busy1), .evt_cnt(evt1)
    );

    // Model: syncd is q_in sampled SYNC_STAGES edges earlier; level flips once the
    // last STABLE_CNT syncd samples all disagree with it.
    bit mqh   [2][16];
    bit msh   [2][16];
    bit mlvl  [2];
    bit mrise [2];
    bit mfall [2];
    bit mbusy [2];
    int mevt  [2];

    task automatic model_clear(input int i);
        for (int j = 0; j < 16; j++) begin
            mqh[i][j] = 1'b0;
            msh[i][j] = 1'b0;
        end
        mlvl[i] = 1'b0; mrise[i] = 1'b0; mfall[i] = 1'b0; mbusy[i] = 1'b0; mevt[i] = 0;
    endtask

    task automatic model_step(input int i, input int ss, input int sc);
        bit s;
        bit acc;
        int run;
        s = mqh[i][ss-1];
        for (int j = 15; j > 0; j--) mqh[i][j] = mqh[i][j-1];
        mqh[i][0] = q_in;
        for (int j = 15; j > 0; j--) msh[i][j] = msh[i][j-1];
        msh[i][0] = s;
        acc = 1'b1;
        for (int j = 0; j < sc; j++) if (msh[i][j] == mlvl[i]) acc = 1'b0;
        if (acc) begin
            mlvl[i]  = s;
            mrise[i] = s;
            mfall[i] = !s;
            mevt[i]  = (mevt[i] + 1) % 256;
        end else begin
            mrise[i] = 1'b0;
            mfall[i] = 1'b0;
        end
        run = 0;
        for (int j = 0; j < sc; j++) begin
            if (msh[i][j] == mlvl[i]) break;
            run++;
        end
        mbusy[i] = (run != 0);
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            model_clear(0);
            model_clear(1);
        end else begin
            model_step(0, 2, 4);
            model_step(1, 3, 1);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        chk("d0.level", 32'(level0), 32'(mlvl[0]));
        chk("d0.rise",  32'(rise0),  32'(mrise[0]));
        chk("d0.fall",  32'(fall0),  32'(mfall[0]));
        chk("d0.busy",  32'(busy0),  32'(mbusy[0]));
        chk("d0.evt",   32'(evt0),   32'(mevt[0]));
        chk("d1.level", 32'(level1), 32'(mlvl[1]));
        chk("d1.rise",  32'(rise1),  32'(mrise[1]));
        chk("d1.fall",  32'(fall1),  32'(mfall[1]));
        chk("d1.busy",  32'(busy1),  32'(mbusy[1]));
        chk("d1.evt",   32'(evt1),   32'(mevt[1]));
        chk("d0.rise_and_fall", 32'(rise0 & fall0), 32'd0);
        if (rise0) rise_seen++;
        if (fall0) fall_seen++;
    end

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic qv);
        @(negedge clk);
        rst  = 1'b0;
        q_in = qv;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int base;
        // Reset, then quiet input
        do_reset(1'b0);
        edges(20);
        chk("quiet.level", 32'(level0), 32'd0);
        chk("quiet.evt",   32'(evt0),   32'd0);

        // Glitch of 3 cycles on default instance: no acceptance
        @(negedge clk) q_in = 1'b1;
        repeat (3) @(negedge clk);
        q_in = 1'b0;
        edges(12);
        chk("glitch.level", 32'(level0), 32'd0);
        chk("glitch.evt",   32'(evt0),   32'd0);
        chk("glitch.busy",  32'(busy0),  32'd0);

        // Clean step: k is the next posedge after the input change
        do_reset(1'b0);
        edges(10);
        @(negedge clk) q_in = 1'b1;
        edges(2);
        chk("step.busy_k1", 32'(busy0), 32'd0);
        chk("step.d1_level_k1", 32'(level1), 32'd0);
        edges(1);
        chk("step.busy_k2", 32'(busy0), 32'd1);
        chk("step.d1_level_k2", 32'(level1), 32'd0);
        edges(1);
        chk("step.d1_level_k3", 32'(level1), 32'd1);
        chk("step.d1_busy_k3",  32'(busy1),  32'd0);
        edges(1);
        chk("step.level_k4", 32'(level0), 32'd0);
        edges(1);
        chk("step.rise_k5",  32'(rise0),  32'd1);
        chk("step.level_k5", 32'(level0), 32'd1);
        chk("step.evt_k5",   32'(evt0),   32'd1);
        edges(1);
        chk("step.rise_k6",  32'(rise0),  32'd0);

        // 256 accepted toggles wrap the 8-bit counter
        do_reset(1'b0);
        edges(4);
        rise_seen = 0;
        fall_seen = 0;
        for (int t = 0; t < 256; t++) begin
            @(negedge clk) q_in = ~q_in;
            repeat (5) @(negedge clk);
        end
        edges(10);
        chk("wrap.evt",   32'(evt0),    32'd0);
        chk("wrap.d1evt", 32'(evt1),    32'd0);
        chk("wrap.rises", 32'(rise_seen), 32'd128);
        chk("wrap.falls", 32'(fall_seen), 32'd128);

        // Reset in the middle of a pending change, released with q_in still high
        edges(5);
        @(negedge clk) q_in = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rstmid.busy",  32'(busy0),  32'd0);
        chk("rstmid.level", 32'(level0), 32'd0);
        chk("rstmid.evt",   32'(evt0),   32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        edges(5);
        chk("rstmid.rise_e5", 32'(rise0), 32'd0);
        edges(1);
        chk("rstmid.rise_e6", 32'(rise0), 32'd1);
        chk("rstmid.evt_e6",  32'(evt0),  32'd1);

        // Randomized segments with occasional reset
        for (int seg = 0; seg < 400; seg++) begin
            @(negedge clk);
            q_in = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 39) == 0) begin
                rst = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
                rst = 1'b1;
            end
            repeat ($urandom_range(1, 7)) @(negedge clk);
        end
        edges(10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/latch_out_debounce.md
Name: latch_out_debounce

Overview:
- Downstream consumer of the D-latch output `q`.
- Brings the latch output into the `clk` domain through a synchronizer chain.
- Filters glitches with a stability counter, producing a clean level, single-cycle rise/fall strobes and a wrap-around count of accepted transitions.
- Sits between the latch-based capture stage and synchronous control logic.

Parameters:
SYNC_STAGES, 2, number of flops in the synchronizer chain; legal range >= 2
STABLE_CNT, 4, consecutive mismatching cycles required before the output level changes; legal range >= 1
EVT_W, 8, width of the accepted-transition counter

Ports:
clk  input  1  single clock; all state updates on its rising edge
rst  input  1  asynchronous, active-low reset; clears all state immediately when low
q_in  input  1  raw latch output, asynchronous to clk
level  output  1  debounced, synchronized level
rise  output  1  one-cycle strobe when `level` goes 0->1
fall  output  1  one-cycle strobe when `level` goes 1->0
busy  output  1  high while the stability counter is nonzero, i.e. a candidate change is pending
evt_cnt  output  EVT_W  number of accepted transitions, modulo 2^EVT_W

Behaviour:
- One clock and one reset only. `rst` is asynchronous and active-low. While `rst` is 0, all flops are cleared:
  - sync chain = 0
  - level = 0
  - rise = 0, fall = 0
  - stability counter cnt = 0, busy = 0
  - evt_cnt = 0
- Synchronizer:
  - `q_in` shifts through SYNC_STAGES flops.
  - `syncd` is the last stage.
  - No logic is permitted between stages.
- Stability counter:
  - cnt is $clog2(STABLE_CNT+1) bits wide and holds the number of consecutive edges on which syncd != level.
- Per rising edge, with priority top to bottom:
  - If syncd == level: cnt <= 0; rise <= 0; fall <= 0.
  - Else if cnt == STABLE_CNT-1:
    - level <= syncd
    - cnt <= 0
    - rise <= syncd
    - fall <= ~syncd
    - evt_cnt <= evt_cnt + 1
  - Else: cnt <= cnt + 1; rise <= 0; fall <= 0.
- busy is combinational (cnt != 0).
- rise and fall are registered. They assert in the same cycle `level` changes, and never both in one cycle.
- Latency:
  - Let `q_in` be stable before capture edge k.
  - `level` changes after edge k + SYNC_STAGES + STABLE_CNT - 1.
  - Defaults: 6 edges including the capture edge.
- Glitch filtering:
  - Any excursion of syncd lasting fewer than STABLE_CNT cycles produces no change on level, rise, fall or evt_cnt.
  - cnt returns to 0 on the first cycle syncd matches level again.
- STABLE_CNT = 1: level follows syncd with one flop of delay; cnt never exceeds 0 and busy stays 0.
- Wrap-around: evt_cnt wraps from 2^EVT_W - 1 to 0 without saturation or flag.
- Reset release with q_in = 1: the block treats this as a real 0->1 transition. rise pulses once after full latency and evt_cnt = 1.
- Reset asserted mid-count or mid-strobe:
  - All state clears in the same instant; a pending transition is discarded.
  - After release, the change is re-qualified from scratch.
- Reset deassertion is assumed synchronized externally. The block does not resynchronize `rst`.

Test Plan:
- Reset, then hold q_in = 0 for 20 cycles -> level = 0, rise = fall = 0, busy = 0, evt_cnt = 0 throughout.
- q_in 0->1 before edge k (defaults) -> busy high from edge k+2; rise = 1 and level = 1 after edge k+5; evt_cnt = 1; rise back to 0 after edge k+6.
- q_in high for 3 cycles, then low (defaults) -> busy pulses, cnt reaches 3 then clears; level stays 0; no rise; evt_cnt unchanged.
- 256 accepted toggles with EVT_W = 8 -> evt_cnt reads 0 after the 256th; rise/fall each counted 128 times; never both high together.
- Reset low two cycles after a 0->1 change on q_in, released 3 cycles later with q_in still 1 -> all outputs 0 during reset; rise occurs 6 edges after the first post-release edge; evt_cnt = 1.
- STABLE_CNT = 1, SYNC_STAGES = 3: q_in step -> level changes after edge k+3; busy never asserts.
